// File: rtl/xge_tx_arbiter.sv
`default_nettype none
// ============================================================================
// xge_tx_arbiter - round-robin whole-packet arbiter onto the xge_mac pkt_tx port
// Revision: 1.0
// ============================================================================
module xge_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 1024
) (
  input  logic                    clk_156m25,
  input  logic                    reset_156m25_n,
  input  logic                    arb_en,
  input  logic [NUM_REQ-1:0]      src_val,
  input  logic [NUM_REQ-1:0]      src_sop,
  input  logic [NUM_REQ-1:0]      src_eop,
  input  logic [3*NUM_REQ-1:0]    src_mod,
  input  logic [64*NUM_REQ-1:0]   src_data,
  output logic [NUM_REQ-1:0]      src_rdy,
  input  logic                    pkt_tx_full,
  output logic                    pkt_tx_val,
  output logic                    pkt_tx_sop,
  output logic                    pkt_tx_eop,
  output logic [2:0]              pkt_tx_mod,
  output logic [63:0]             pkt_tx_data,
  output logic [NUM_REQ-1:0]      grant_vec,
  output logic                    sop_err,
  output logic                    trunc,
  output logic [31:0]             pkt_count
);

  localparam int c_OW_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_OW_W-1:0]   r_owner;
  logic [c_OW_W-1:0]   r_last_owner;
  logic [c_BEAT_W-1:0] r_beat_cnt;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_stray;
  logic                w_found;
  logic [c_OW_W-1:0]   w_pick;
  int                  w_idx;

  logic                w_own_val;
  logic                w_own_sop;
  logic                w_own_eop;
  logic [2:0]          w_own_mod;
  logic [63:0]         w_own_data;
  logic                w_own_xfer;

  assign w_req   = src_val & src_sop;
  assign w_stray = src_val & ~src_sop;

  // Rotating scan: the slot after the last owner is checked first.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_owner) + k) % NUM_REQ;
      if (!w_found && w_req[c_OW_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = c_OW_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_own_val  = 1'b0;
    w_own_sop  = 1'b0;
    w_own_eop  = 1'b0;
    w_own_mod  = '0;
    w_own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == c_OW_W'(i)) begin
        w_own_val  = src_val[i];
        w_own_sop  = src_sop[i];
        w_own_eop  = src_eop[i];
        w_own_mod  = src_mod[3*i +: 3];
        w_own_data = src_data[64*i +: 64];
      end
    end
  end

  assign w_own_xfer = w_own_val &&
                      (((r_state == ST_XFER) && !pkt_tx_full) || (r_state == ST_DROP));

  // Beats without sop seen while idle are accepted so a broken source cannot stall.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdy
    assign src_rdy[gi] = ((r_state == ST_XFER) && (r_owner == c_OW_W'(gi)) && !pkt_tx_full)
                       || ((r_state == ST_DROP) && (r_owner == c_OW_W'(gi)))
                       || ((r_state == ST_IDLE) && w_stray[gi]);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= c_OW_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      pkt_tx_val   <= 1'b0;
      pkt_tx_sop   <= 1'b0;
      pkt_tx_eop   <= 1'b0;
      pkt_tx_mod   <= '0;
      pkt_tx_data  <= '0;
      grant_vec    <= '0;
      sop_err      <= 1'b0;
      trunc        <= 1'b0;
      pkt_count    <= '0;
    end else begin
      pkt_tx_val <= 1'b0;
      pkt_tx_sop <= 1'b0;
      pkt_tx_eop <= 1'b0;
      pkt_tx_mod <= '0;
      sop_err    <= 1'b0;
      trunc      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_stray) begin
            sop_err <= 1'b1;
          end
          if (arb_en && w_found) begin
            r_state      <= ST_XFER;
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            r_beat_cnt   <= '0;
            grant_vec    <= NUM_REQ'(1) << w_pick;
          end
        end
        ST_XFER: begin
          if (w_own_xfer) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_sop  <= (r_beat_cnt == '0);
            pkt_tx_data <= w_own_data;
            r_beat_cnt  <= r_beat_cnt + c_BEAT_W'(1);
            if (w_own_sop && (r_beat_cnt != '0)) begin
              sop_err <= 1'b1;
            end
            if (w_own_eop) begin
              pkt_tx_eop <= 1'b1;
              pkt_tx_mod <= w_own_mod;
              pkt_count  <= pkt_count + 32'd1;
              r_state    <= ST_IDLE;
              grant_vec  <= '0;
            end else if (r_beat_cnt == c_LAST_BEAT) begin
              // Close the packet towards the MAC and swallow the rest of it.
              pkt_tx_eop <= 1'b1;
              trunc      <= 1'b1;
              pkt_count  <= pkt_count + 32'd1;
              r_state    <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (w_own_xfer && w_own_eop) begin
            r_state   <= ST_IDLE;
            grant_vec <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          grant_vec <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
